// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Stall and flush controller for a six-stage in-order pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
//
// Stall requests are priority encoded with no latency. A stage stalling
// freezes itself and every stage upstream of it.
//
// A taken branch resolved in EX normally flushes IF/ID and ID/EX in the same
// cycle. If EX or MEM is busy, the EX/MEM register is held (stall[3]=1). A
// flush must never coincide with that hold, so in that case the first branch
// target is parked in pend_target. The flush is then issued on the first cycle
// where both EX and MEM are free.
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   defined   : saturating 32-bit counters of stalled cycles and flush pulses.
//   undefined : both counter outputs are tied to 0 and no counter flops exist.
//
// Ports
//   clk            in   1       pipeline clock, rising edge
//   rst            in   1       asynchronous reset, active low
//   stallreq_if    in   1       fetch waiting on instruction memory
//   stallreq_id    in   1       decode load-use hazard
//   stallreq_ex    in   1       execute multi-cycle op busy
//   stallreq_mem   in   1       memory stage access busy
//   branch_flag    in   1       taken branch/jump resolved in EX
//   branch_target  in   DATA_W  target PC of that branch
//   stall          out  6       per-stage hold, bit0 = PC ... bit5 = WB
//   flush          out  1       kill IF/ID and ID/EX this cycle
//   new_pc         out  DATA_W  PC to load when flush=1, else 0
//   stall_cycles   out  32      cycles with stall[0]=1
//   flush_count    out  32      number of flush pulses
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              branch_flag,
  input  logic [DATA_W-1:0] branch_target,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [DATA_W-1:0] new_pc,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] pend_target;
  logic [DATA_W-1:0] pend_target_nxt;

  logic [5:0]        stall_req;
  logic              back_free;
  logic              flush_int;
  logic [DATA_W-1:0] new_pc_int;

  // Priority encode: the deepest busy stage wins, and it holds itself and all
  // stages upstream of it.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem) begin
      stall_req = 6'b011111;
    end else if (stallreq_ex) begin
      stall_req = 6'b001111;
    end else if (stallreq_id) begin
      stall_req = 6'b000111;
    end else if (stallreq_if) begin
      stall_req = 6'b000011;
    end
  end

  // EX/MEM is only released when neither EX nor MEM is busy. This is the only
  // condition under which a flush is permitted.
  assign back_free = !stallreq_ex && !stallreq_mem;

  // Next-state and flush decision
  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    flush_int       = 1'b0;
    new_pc_int      = '0;
    case (state)
      RUN: begin
        if (branch_flag) begin
          if (back_free) begin
            flush_int  = 1'b1;
            new_pc_int = branch_target;
          end else begin
            // Back end is held: remember the target and flush later.
            state_nxt       = PEND;
            pend_target_nxt = branch_target;
          end
        end
      end
      PEND: begin
        // Any later branch_flag comes from an instruction that the pending
        // flush will kill, so it is ignored here.
        if (back_free) begin
          flush_int  = 1'b1;
          new_pc_int = pend_target;
          state_nxt  = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // Outputs are gated by reset directly, so they drop the moment rst falls.
  // A flush overrides any front-end stall so the redirected fetch proceeds.
  assign flush  = rst & flush_int;
  assign new_pc = rst ? new_pc_int : '0;
  assign stall  = (!rst || flush_int) ? 6'b000000 : stall_req;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      return val;
    end
    return val + 32'd1;
  endfunction

  // Performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall[0]) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stallreq_if   = 1'b0;
    stallreq_id   = 1'b0;
    stallreq_ex   = 1'b0;
    stallreq_mem  = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
  endtask

  logic [3:0] req_v [8];
  logic [5:0] exp_v [8];

  initial begin
    // req bits: [3]=mem [2]=ex [1]=id [0]=if
    req_v[0] = 4'b1111; exp_v[0] = 6'b011111;
    req_v[1] = 4'b0111; exp_v[1] = 6'b001111;
    req_v[2] = 4'b0011; exp_v[2] = 6'b000111;
    req_v[3] = 4'b0001; exp_v[3] = 6'b000011;
    req_v[4] = 4'b0000; exp_v[4] = 6'b000000;
    req_v[5] = 4'b1000; exp_v[5] = 6'b011111;
    req_v[6] = 4'b0100; exp_v[6] = 6'b001111;
    req_v[7] = 4'b0010; exp_v[7] = 6'b000111;

    // Reset with every request and a branch active: outputs must be quiet
    rst = 1'b0;
    idle();
    stallreq_mem  = 1'b1;
    stallreq_if   = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h0000_1234;
    @(negedge clk);
    #1;
    chk("rst_stall",  32'(stall), 32'h0);
    chk("rst_flush",  32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_scyc",   stall_cycles, 32'h0);
    chk("rst_fcnt",   flush_count, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;

    // Priority encoding table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req_v[i];
      #1;
      chk($sformatf("prio_%0d", i), 32'(stall), 32'(exp_v[i]));
      chk($sformatf("prio_flush_%0d", i), 32'(flush), 32'h0);
    end

    // if+id+ex, then drop ex within the same cycle
    @(negedge clk);
    idle();
    stallreq_if = 1'b1;
    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    #1;
    chk("drop_ex_before", 32'(stall), 32'h0F);
    #2;
    stallreq_ex = 1'b0;
    #1;
    chk("drop_ex_after", 32'(stall), 32'h07);

    // Immediate branch, with front-end stall requests that must be overridden
    @(negedge clk);
    idle();
    stallreq_if   = 1'b1;
    stallreq_id   = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h0000_1000;
    #1;
    chk("imm_flush",  32'(flush), 32'h1);
    chk("imm_new_pc", new_pc, 32'h0000_1000);
    chk("imm_stall",  32'(stall), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("imm_after_flush",  32'(flush), 32'h0);
    chk("imm_after_new_pc", new_pc, 32'h0);

    // Deferred branch: MEM busy three cycles, second target must be ignored
    @(negedge clk);
    idle();
    stallreq_mem  = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h0000_0200;
    #1;
    chk("def_c1_flush",  32'(flush), 32'h0);
    chk("def_c1_new_pc", new_pc, 32'h0);
    chk("def_c1_stall",  32'(stall), 32'h1F);
    @(negedge clk);
    branch_target = 32'h0000_0300;
    #1;
    chk("def_c2_flush", 32'(flush), 32'h0);
    chk("def_c2_stall", 32'(stall), 32'h1F);
    @(negedge clk);
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    #1;
    chk("def_c3_flush",  32'(flush), 32'h0);
    chk("def_c3_new_pc", new_pc, 32'h0);
    @(negedge clk);
    idle();
    stallreq_id = 1'b1;
    #1;
    chk("def_rel_flush",  32'(flush), 32'h1);
    chk("def_rel_new_pc", new_pc, 32'h0000_0200);
    chk("def_rel_stall",  32'(stall), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("def_done_flush", 32'(flush), 32'h0);

    // Reset while PEND: pending branch must be discarded
    @(negedge clk);
    idle();
    stallreq_ex   = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h0000_0500;
    #1;
    chk("rp_enter_flush", 32'(flush), 32'h0);
    @(negedge clk);
    branch_flag = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rp_stall",  32'(stall), 32'h0);
    chk("rp_flush",  32'(flush), 32'h0);
    chk("rp_new_pc", new_pc, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    chk("rp_rel_flush",  32'(flush), 32'h0);
    chk("rp_rel_new_pc", new_pc, 32'h0);
    @(negedge clk);
    #1;
    chk("rp_rel2_flush", 32'(flush), 32'h0);

    // Counters: fresh reset, 5 stalled cycles, then 2 branches
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    stallreq_id = 1'b1;
    repeat (5) @(negedge clk);
    idle();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      branch_flag   = 1'b1;
      branch_target = 32'h0000_0040;
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    chk("cnt_stall_cycles", stall_cycles, 32'd5);
    chk("cnt_flush_count",  flush_count, 32'd2);

    // Preload near the top and confirm saturation
    force dut.stall_cnt = 32'hFFFF_FFFD;
    force dut.flush_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    @(negedge clk);
    stallreq_id = 1'b1;
    repeat (4) @(negedge clk);
    idle();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      branch_flag   = 1'b1;
      branch_target = 32'h0000_0080;
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    #1;
    chk("sat_stall_cycles", stall_cycles, 32'hFFFF_FFFF);
    chk("sat_flush_count",  flush_count, 32'hFFFF_FFFF);
`else
    chk("cnt_off_stall_cycles", stall_cycles, 32'd0);
    chk("cnt_off_flush_count",  flush_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
